insmem_loader: RTL and testbench
================================

INSMEM_LOADER -- requirements
Module: insmem_loader

Interface
REQ-001 Parameter MEM_BYTES, default 400: instruction memory capacity in bytes; MAX_WORDS = MEM_BYTES/4.
REQ-002 Parameter BASE_ADDR, default 32'h0: byte address of the first word written.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  single-cycle load request; word_count is sampled in the same cycle.
REQ-006 word_count  input  8  number of 32-bit words to load.
REQ-007 abort  input  1  terminates an in-progress load.
REQ-008 in_valid  input  1  byte-stream source has in_data available.
REQ-009 in_data  input  8  program byte, little-endian within each word.
REQ-010 in_ready  output  1  loader accepts a byte this cycle.
REQ-011 wr_en  output  1  instruction-memory word write strobe.
REQ-012 wr_addr  output  32  byte address of the word's byte 0, word-aligned.
REQ-013 wr_data  output  32  {byte3, byte2, byte1, byte0}.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 cpu_hold  output  1  equals busy; holds the core in reset during a load.
REQ-016 done  output  1  one-cycle pulse on successful completion.
REQ-017 error  output  1  one-cycle pulse on a rejected start.

Function
REQ-018 States SHALL be IDLE, RECV, WRITE and DONE, and all outputs SHALL be registered.
REQ-019 A byte SHALL transfer on a rising edge where in_valid=1 and in_ready=1, and in_ready SHALL be 1 only in RECV.
REQ-020 IDLE, start=1 with 1 <= word_count <= MAX_WORDS: latch word_count, clear word_idx and byte_idx, and go to RECV.
REQ-021 IDLE, start=1 with word_count=0 or word_count > MAX_WORDS: pulse error for one cycle, remain in IDLE, and issue no write.
REQ-022 RECV: the k-th accepted byte (k = 0..3) SHALL be placed in wr_data bits [8k+7:8k].
REQ-023 The 4th byte handshake SHALL cause a transition to WRITE, and in_ready SHALL be 0 in the following cycle.
REQ-024 WRITE SHALL last exactly one cycle with wr_en=1 and wr_addr = BASE_ADDR + 4*word_idx.
REQ-025 After WRITE, the loader SHALL go to DONE if word_idx+1 == latched count; otherwise it SHALL increment word_idx and return to RECV.
REQ-026 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-027 busy SHALL fall in the cycle after done.
REQ-028 wr_en SHALL be 0 in every state except WRITE, and wr_addr and wr_data SHALL hold their last values otherwise.
REQ-029 start while busy SHALL be ignored and SHALL NOT re-latch word_count.
REQ-030 abort in RECV or WRITE SHALL return the loader to IDLE on the next edge with no write that cycle and no done pulse.
REQ-031 A partially assembled word at abort SHALL be discarded.
REQ-032 abort and start in the same IDLE cycle: start SHALL take priority, and abort SHALL have no effect in IDLE.
REQ-033 in_valid gaps SHALL stall assembly indefinitely without timeout, and byte_idx SHALL advance only on a handshake.
REQ-034 Throughput SHALL be at most one word per 5 cycles (4 byte cycles plus 1 write cycle).
REQ-035 word_idx SHALL never exceed MAX_WORDS-1, so wr_addr+3 < BASE_ADDR+MEM_BYTES always holds.

Reset
REQ-036 While rst=1 the loader SHALL be in IDLE with all counters 0, all outputs 0, and cpu_hold=0.
REQ-037 Reset asserted mid-load SHALL abandon the load immediately, with no further write or done.

Verification
REQ-038 Normal load: start, word_count=2, bytes 93 00 80 01 93 02 20 00 -> writes (0x00, 0x01800093) then (0x04, 0x00200293), done one cycle after the second wr_en, busy low one cycle later.
REQ-039 Rejected start: word_count=0, then word_count=101 -> one error pulse each, no wr_en, and busy stays 0.
REQ-040 Bursty source: in_valid toggled 1,0,0,1,... -> wr_data identical to the gapless case, and wr_en occurs only after the 4th accepted byte.
REQ-041 Abort: abort pulsed after 2 bytes of word 1 in a 3-word load -> exactly one write (addr 0x00), no done, then idle; a new start loads from addr 0x00.
REQ-042 Start while busy: second start with word_count=5 during a 1-word load -> exactly 1 write and 1 done.
REQ-043 Reset mid-WRITE: rst asserted in the WRITE cycle -> all outputs 0 asynchronously, and no done.

Source files
------------

// File: rtl/insmem_loader.sv
// -----------------------------------------------------------------------------
// insmem_loader
//
// Boot-time instruction memory loader. A single-cycle start request latches a
// word count. The loader then assembles that many 32-bit words from a
// little-endian byte stream and writes each word to instruction memory at
// consecutive word-aligned addresses starting at BASE_ADDR. While a load is in
// progress, busy/cpu_hold keep the core in reset.
//
// Handshake: a byte moves on a rising edge where in_valid_i=1 and in_ready_o=1.
// The source must hold in_data_i stable while in_valid_i=1 and in_ready_o=0.
// in_ready_o is high only while the loader is receiving bytes.
//
// Parameters
//   MEM_BYTES    instruction memory capacity in bytes (MAX_WORDS = MEM_BYTES/4)
//   BASE_ADDR    byte address of the first word written
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          asynchronous active-high reset
//   start_i        single-cycle load request, word_count_i sampled with it
//   word_count_i   number of 32-bit words to load (1..MAX_WORDS accepted)
//   abort_i        terminates an in-progress load, the partial word is dropped
//   in_valid_i     byte-stream source has in_data_i available
//   in_data_i      program byte, little-endian within each word
//   in_ready_o     loader accepts a byte this cycle
//   wr_en_o        instruction-memory word write strobe
//   wr_addr_o      byte address of the word's byte 0 (word aligned)
//   wr_data_o      assembled word {byte3, byte2, byte1, byte0}
//   busy_o         high whenever the loader is not idle
//   cpu_hold_o     equals busy_o, holds the core in reset during a load
//   done_o         one-cycle pulse on successful completion
//   error_o        one-cycle pulse on a rejected start
//   dbg_state_o    current FSM state (IDLE=0, RECV=1, WRITE=2, DONE=3)
// -----------------------------------------------------------------------------
module insmem_loader #(
    parameter int          MEM_BYTES = 400,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  word_count_i,
    input  logic        abort_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    output logic        wr_en_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic        busy_o,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic        error_o,
    output logic [1:0]  dbg_state_o
);

    localparam logic [31:0] MAX_WORDS = 32'(MEM_BYTES / 4);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // FSM and counters
    logic [1:0]  state_q,    state_d;
    logic [7:0]  count_q,    count_d;
    logic [7:0]  word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;

    // Bytes 0..2 of the word being assembled; byte 3 goes straight into
    // wr_data so that wr_data only changes when a complete word is ready.
    logic [23:0] asm_q,      asm_d;

    // Registered outputs
    logic [31:0] wr_addr_q,  wr_addr_d;
    logic [31:0] wr_data_q,  wr_data_d;
    logic        error_d;
    logic        in_ready_q;
    logic        wr_en_q;
    logic        busy_q;
    logic        cpu_hold_q;
    logic        done_q;
    logic        error_q;

    logic [31:0] count_ext;
    logic        start_ok;
    logic        handshake;
    logic        last_word;

    assign count_ext = {24'd0, word_count_i};
    assign start_ok  = (count_ext != 32'd0) && (count_ext <= MAX_WORDS);

    // in_ready_q is registered from the next state, so it is high exactly
    // while state_q is RECV; a handshake therefore only happens in RECV.
    assign handshake = in_valid_i && in_ready_q;

    // word_idx never exceeds count-1 <= 254, so the 8-bit increment cannot wrap.
    assign last_word = ((word_idx_q + 8'd1) == count_q);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        error_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort has no effect here; start always wins.
                if (start_i) begin
                    if (start_ok) begin
                        count_d    = word_count_i;
                        word_idx_d = 8'd0;
                        byte_idx_d = 2'd0;
                        asm_d      = 24'd0;
                        state_d    = S_RECV;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            S_RECV: begin
                if (abort_i) begin
                    // Drop the partial word; a byte offered this cycle is not taken.
                    state_d    = S_IDLE;
                    count_d    = 8'd0;
                    word_idx_d = 8'd0;
                    byte_idx_d = 2'd0;
                    asm_d      = 24'd0;
                end else if (handshake) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: asm_d[7:0]   = in_data_i;
                        2'd1: asm_d[15:8]  = in_data_i;
                        2'd2: asm_d[23:16] = in_data_i;
                        default: begin
                            wr_data_d = {in_data_i, asm_q};
                            wr_addr_d = BASE_ADDR + {22'd0, word_idx_q, 2'b00};
                            state_d   = S_WRITE;
                        end
                    endcase
                end
            end

            S_WRITE: begin
                // The write strobe for this word is already on the bus; an
                // abort here only prevents any further words and the done pulse.
                if (abort_i) begin
                    state_d    = S_IDLE;
                    count_d    = 8'd0;
                    word_idx_d = 8'd0;
                    byte_idx_d = 2'd0;
                    asm_d      = 24'd0;
                end else if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    word_idx_d = word_idx_q + 8'd1;
                    byte_idx_d = 2'd0;
                    asm_d      = 24'd0;
                    state_d    = S_RECV;
                end
            end

            S_DONE: begin
                state_d    = S_IDLE;
                count_d    = 8'd0;
                word_idx_d = 8'd0;
                byte_idx_d = 2'd0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and registered outputs. Status outputs are computed from the next
    // state so that they line up with the state they describe.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            count_q    <= 8'd0;
            word_idx_q <= 8'd0;
            byte_idx_q <= 2'd0;
            asm_q      <= 24'd0;
            wr_addr_q  <= 32'd0;
            wr_data_q  <= 32'd0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            in_ready_q <= (state_d == S_RECV);
            wr_en_q    <= (state_d == S_WRITE);
            busy_q     <= (state_d != S_IDLE);
            cpu_hold_q <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
            error_q    <= error_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign busy_o      = busy_q;
    assign cpu_hold_o  = cpu_hold_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_insmem_loader.sv
// -----------------------------------------------------------------------------
// tb_insmem_loader
//
// Drives random and directed loads into insmem_loader. The reference model is
// a program byte array: a completed word w is expected to appear as one write
// of {b[4w+3], b[4w+2], b[4w+1], b[4w]} at BASE + 4*w. Expected writes sit in
// a queue that a negedge monitor drains whenever wr_en_o is seen.
// -----------------------------------------------------------------------------
module tb_insmem_loader;

    localparam int          MEM_BYTES = 400;
    localparam logic [31:0] BASE      = 32'h0;
    localparam int          MAX_WORDS = MEM_BYTES / 4;

    // ---------------- clock / reset ----------------
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  word_count_i = 8'd0;
    logic        abort_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [7:0]  in_data_i = 8'd0;
    logic        in_ready_o;
    logic        wr_en_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic        busy_o;
    logic        cpu_hold_o;
    logic        done_o;
    logic        error_o;
    logic [1:0]  dbg_state_o;

    always #5 clk_i = ~clk_i;

    insmem_loader #(
        .MEM_BYTES (MEM_BYTES),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .word_count_i (word_count_i),
        .abort_i      (abort_i),
        .in_valid_i   (in_valid_i),
        .in_data_i    (in_data_i),
        .in_ready_o   (in_ready_o),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o),
        .cpu_hold_o   (cpu_hold_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          exp_done = 0;
    int          exp_err  = 0;
    int          seen_done = 0;
    int          seen_err  = 0;
    logic [7:0]  prog [0:511];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_outs(input string tag, input logic b, input logic r, input logic d);
        check({tag, "_busy"},     32'(busy_o),     32'(b));
        check({tag, "_cpu_hold"}, 32'(cpu_hold_o), 32'(b));
        check({tag, "_in_ready"}, 32'(in_ready_o), 32'(r));
        check({tag, "_done"},     32'(done_o),     32'(d));
    endtask

    // ---------------- monitor ----------------
    logic        prev_wr_en = 1'b0;
    logic        prev_done  = 1'b0;
    logic [31:0] last_addr  = 32'd0;
    logic [31:0] last_data  = 32'd0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_wr_en = 1'b0;
            prev_done  = 1'b0;
            last_addr  = 32'd0;
            last_data  = 32'd0;
        end else begin
            if (wr_en_o) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_wr", 32'd1, 32'd0);
                end else begin
                    check("wr_addr", wr_addr_o, exp_addr_q.pop_front());
                    check("wr_data", wr_data_o, exp_data_q.pop_front());
                end
                last_addr = wr_addr_o;
                last_data = wr_data_o;
            end else begin
                check("wr_addr_hold", wr_addr_o, last_addr);
                check("wr_data_hold", wr_data_o, last_data);
            end
            if (done_o) begin
                seen_done++;
                check("done_after_wr", 32'(prev_wr_en), 32'd1);
            end
            if (prev_done) check("busy_after_done", 32'(busy_o), 32'd0);
            if (error_o) seen_err++;
            prev_wr_en = wr_en_o;
            prev_done  = done_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill_random(input int n);
        for (int i = 0; i < 4 * n; i++) prog[i] = 8'($urandom_range(0, 255));
    endtask

    // gap: percent of idle in_valid cycles, or negative for the fixed 1,0,0 pattern.
    // abort_at: accepted-byte count at which abort is pulsed (-1 = never).
    // restart_at: accepted-byte count at which a second start (count 5) is pulsed.
    task automatic do_load(input int n, input int gap, input int abort_at,
                           input int restart_at, input logic abort_with_start);
        int   acc;
        int   cyc;
        int   w;
        logic v;
        acc = 0;
        cyc = 0;
        start_i      = 1'b1;
        word_count_i = 8'(n);
        abort_i      = abort_with_start;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        abort_i = 1'b0;
        while (acc < 4 * n) begin
            expect_outs("recv", 1'b1, 1'b1, 1'b0);
            if (acc == abort_at) begin
                abort_i    = 1'b1;
                in_valid_i = 1'($urandom_range(0, 1));
                in_data_i  = 8'($urandom_range(0, 255));
                @(posedge clk_i); #1;
                abort_i    = 1'b0;
                in_valid_i = 1'b0;
                expect_outs("after_abort", 1'b0, 1'b0, 1'b0);
                check("wr_en_after_abort", 32'(wr_en_o), 32'd0);
                return;
            end
            if (gap < 0) v = ((cyc % 3) == 0);
            else         v = ($urandom_range(0, 99) >= gap);
            in_valid_i = v;
            in_data_i  = prog[acc];
            if (acc == restart_at) begin
                start_i      = 1'b1;
                word_count_i = 8'd5;
            end
            @(posedge clk_i); #1;
            start_i = 1'b0;
            cyc++;
            if (cyc > 20000) begin
                check("load_timeout", 32'd1, 32'd0);
                in_valid_i = 1'b0;
                return;
            end
            if (v) begin
                acc++;
                if ((acc % 4) == 0) begin
                    w = acc / 4 - 1;
                    exp_addr_q.push_back(BASE + 32'(4 * w));
                    exp_data_q.push_back({prog[4*w+3], prog[4*w+2], prog[4*w+1], prog[4*w]});
                    check("in_ready_write", 32'(in_ready_o), 32'd0);
                    check("wr_en_write",    32'(wr_en_o),    32'd1);
                    // Offer a byte during the write cycle; it must not be taken.
                    in_valid_i = 1'($urandom_range(0, 1));
                    in_data_i  = (acc < 4 * n) ? prog[acc] : 8'($urandom_range(0, 255));
                    @(posedge clk_i); #1;
                    cyc++;
                    if (acc == 4 * n) begin
                        in_valid_i = 1'b0;
                        expect_outs("done_cycle", 1'b1, 1'b0, 1'b1);
                        check("wr_en_done_cycle", 32'(wr_en_o), 32'd0);
                        exp_done++;
                        @(posedge clk_i); #1;
                        expect_outs("after_done", 1'b0, 1'b0, 1'b0);
                    end
                end
            end
        end
    endtask

    task automatic bad_start(input int wc);
        start_i      = 1'b1;
        word_count_i = 8'(wc);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        exp_err++;
        check("error_pulse", 32'(error_o), 32'd1);
        check("wr_en_rejected", 32'(wr_en_o), 32'd0);
        expect_outs("rejected", 1'b0, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        check("error_one_cycle", 32'(error_o), 32'd0);
        expect_outs("idle_after_err", 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int ab;
        repeat (3) @(posedge clk_i);
        #1;
        expect_outs("reset", 1'b0, 1'b0, 1'b0);
        check("reset_wr_en",   32'(wr_en_o),   32'd0);
        check("reset_wr_addr", wr_addr_o,      32'd0);
        check("reset_wr_data", wr_data_o,      32'd0);
        check("reset_error",   32'(error_o),   32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        expect_outs("idle", 1'b0, 1'b0, 1'b0);

        // Known two-word program, gapless then bursty 1,0,0 pattern.
        prog[0] = 8'h93; prog[1] = 8'h00; prog[2] = 8'h80; prog[3] = 8'h01;
        prog[4] = 8'h93; prog[5] = 8'h02; prog[6] = 8'h20; prog[7] = 8'h00;
        do_load(2, 0, -1, -1, 1'b0);
        do_load(2, -1, -1, -1, 1'b0);

        // Rejected starts.
        bad_start(0);
        bad_start(MAX_WORDS + 1);
        bad_start(255);

        // Abort after 2 bytes of word 1 of a 3-word load, then reload from 0.
        fill_random(3);
        do_load(3, 20, 6, -1, 1'b0);
        fill_random(2);
        do_load(2, 0, -1, -1, 1'b0);

        // Second start while busy must be ignored.
        fill_random(1);
        do_load(1, 30, -1, 2, 1'b0);

        // abort together with start in IDLE: start wins.
        fill_random(2);
        do_load(2, 0, -1, -1, 1'b1);

        // Largest accepted load.
        fill_random(MAX_WORDS);
        do_load(MAX_WORDS, 0, -1, -1, 1'b0);

        // Random loads, some aborted.
        for (int t = 0; t < 12; t++) begin
            n  = $urandom_range(1, 6);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * n - 1) : -1;
            fill_random(n);
            do_load(n, $urandom_range(0, 70), ab, -1, 1'b0);
        end

        // Reset asserted in the WRITE cycle of word 0.
        fill_random(2);
        start_i      = 1'b1;
        word_count_i = 8'd2;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = prog[i];
            @(posedge clk_i); #1;
        end
        in_valid_i = 1'b0;
        check("wr_en_pre_rst",   32'(wr_en_o), 32'd1);
        check("wr_addr_pre_rst", wr_addr_o,    BASE);
        check("wr_data_pre_rst", wr_data_o,    {prog[3], prog[2], prog[1], prog[0]});
        rst_i = 1'b1;
        #1;
        expect_outs("async_rst", 1'b0, 1'b0, 1'b0);
        check("async_rst_wr_en",   32'(wr_en_o), 32'd0);
        check("async_rst_wr_addr", wr_addr_o,    32'd0);
        check("async_rst_wr_data", wr_data_o,    32'd0);
        check("async_rst_error",   32'(error_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        expect_outs("idle_after_rst", 1'b0, 1'b0, 1'b0);

        fill_random(3);
        do_load(3, 40, -1, -1, 1'b0);

        repeat (3) @(posedge clk_i);
        #1;
        check("done_count",  32'(seen_done), 32'(exp_done));
        check("error_count", 32'(seen_err),  32'(exp_err));
        check("writes_left", 32'(exp_addr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
